// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (icache / dcache) arbiter in front of a fixed-latency
// line memory. Exactly one memory transaction is in flight at a time.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   ic_req_in / ic_addr_in   icache refill request (held until ack)
//   ic_ack_out / ic_rdata_out one-cycle completion pulse and returned line
//   dc_req_in / dc_we_in / dc_addr_in / dc_wdata_in
//                            dcache refill (we=0) or writeback (we=1) request
//   dc_ack_out / dc_rdata_out one-cycle completion pulse and returned line
//   mem_req_out / mem_we_out / mem_addr_out / mem_wdata_out
//                            one-cycle memory command, line-aligned address
//   mem_rdata_in             read data, valid MEM_LATENCY cycles after command
//   busy_out                 high whenever a transaction is in progress
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 128,
  parameter int unsigned MEM_LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_in,
  input  logic [ADDR_W-1:0] ic_addr_in,
  output logic              ic_ack_out,
  output logic [LINE_W-1:0] ic_rdata_out,
  input  logic              dc_req_in,
  input  logic              dc_we_in,
  input  logic [ADDR_W-1:0] dc_addr_in,
  input  logic [LINE_W-1:0] dc_wdata_in,
  output logic              dc_ack_out,
  output logic [LINE_W-1:0] dc_rdata_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [LINE_W-1:0] mem_wdata_out,
  input  logic [LINE_W-1:0] mem_rdata_in,
  output logic              busy_out
);

  localparam int unsigned OFFS_W = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W  = 4;
  // Clears the byte-within-line offset bits.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFS_W) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_t;

  state_t             state_q, state_d;
  grant_t             grant_q, grant_d;
  grant_t             last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;

  logic               win_dc;
  logic [LINE_W-1:0]  resp_data;

  logic               mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_d;
  logic               ic_ack_d, dc_ack_d;
  logic [LINE_W-1:0]  ic_rdata_d, dc_rdata_d;
  logic               busy_d;

  // Next-state and next-output logic; every output is registered from *_d.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_out;
    mem_wdata_d = mem_wdata_out;
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
    ic_rdata_d  = '0;
    dc_rdata_d  = '0;
    resp_data   = '0;

    // On a tie the port that was not granted last wins.
    if (ic_req_in && dc_req_in) begin
      win_dc = (last_q == GNT_IC);
    end else begin
      win_dc = dc_req_in;
    end

    unique case (state_q)
      IDLE: begin
        if (ic_req_in || dc_req_in) begin
          grant_d     = win_dc ? GNT_DC : GNT_IC;
          last_d      = grant_d;
          we_d        = win_dc ? dc_we_in : 1'b0;
          // Command registers are loaded here so they are valid during ISSUE.
          mem_req_d   = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = (win_dc ? dc_addr_in : ic_addr_in) & LINE_MASK;
          mem_wdata_d = win_dc ? dc_wdata_in : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_q reaches 1 exactly MEM_LATENCY cycles after the ISSUE cycle.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d     = '0;
          resp_data = we_q ? '0 : mem_rdata_in;
          if (grant_q == GNT_DC) begin
            dc_ack_d   = 1'b1;
            dc_rdata_d = resp_data;
          end else begin
            ic_ack_d   = 1'b1;
            ic_rdata_d = resp_data;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= GNT_IC;
      last_q        <= GNT_DC;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      ic_ack_out    <= 1'b0;
      dc_ack_out    <= 1'b0;
      ic_rdata_out  <= '0;
      dc_rdata_out  <= '0;
      busy_out      <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      mem_req_out   <= mem_req_d;
      mem_we_out    <= mem_we_d;
      mem_addr_out  <= mem_addr_d;
      mem_wdata_out <= mem_wdata_d;
      ic_ack_out    <= ic_ack_d;
      dc_ack_out    <= dc_ack_d;
      ic_rdata_out  <= ic_rdata_d;
      dc_rdata_out  <= dc_rdata_d;
      busy_out      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance u_dut uses
// MEM_LATENCY=5, instance u_dut1 uses MEM_LATENCY=1. A small memory model
// drives the pattern only in the exact cycle read data is due.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0 (latency 5)
  logic              ic_req0, dc_req0, dc_we0;
  logic [ADDR_W-1:0] ic_addr0, dc_addr0;
  logic [LINE_W-1:0] dc_wdata0;
  logic              ic_ack0, dc_ack0, mem_req0, mem_we0, busy0;
  logic [LINE_W-1:0] ic_rdata0, dc_rdata0, mem_wdata0, mem_rdata0;
  logic [ADDR_W-1:0] mem_addr0;

  // Instance 1 (latency 1)
  logic              ic_req1, dc_req1, dc_we1;
  logic [ADDR_W-1:0] ic_addr1, dc_addr1;
  logic [LINE_W-1:0] dc_wdata1;
  logic              ic_ack1, dc_ack1, mem_req1, mem_we1, busy1;
  logic [LINE_W-1:0] ic_rdata1, dc_rdata1, mem_wdata1, mem_rdata1;
  logic [ADDR_W-1:0] mem_addr1;

  logic [LINE_W-1:0] rd_pattern;
  logic [LINE_W-1:0] junk = {4{32'hDEADBEEF}};
  logic [7:0]        pipe0 = '0;
  logic              pipe1 = 1'b0;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LATENCY(5)) u_dut (
    .clk(clk), .rst(rst),
    .ic_req_in(ic_req0), .ic_addr_in(ic_addr0),
    .ic_ack_out(ic_ack0), .ic_rdata_out(ic_rdata0),
    .dc_req_in(dc_req0), .dc_we_in(dc_we0), .dc_addr_in(dc_addr0),
    .dc_wdata_in(dc_wdata0),
    .dc_ack_out(dc_ack0), .dc_rdata_out(dc_rdata0),
    .mem_req_out(mem_req0), .mem_we_out(mem_we0), .mem_addr_out(mem_addr0),
    .mem_wdata_out(mem_wdata0), .mem_rdata_in(mem_rdata0),
    .busy_out(busy0)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .ic_req_in(ic_req1), .ic_addr_in(ic_addr1),
    .ic_ack_out(ic_ack1), .ic_rdata_out(ic_rdata1),
    .dc_req_in(dc_req1), .dc_we_in(dc_we1), .dc_addr_in(dc_addr1),
    .dc_wdata_in(dc_wdata1),
    .dc_ack_out(dc_ack1), .dc_rdata_out(dc_rdata1),
    .mem_req_out(mem_req1), .mem_we_out(mem_we1), .mem_addr_out(mem_addr1),
    .mem_wdata_out(mem_wdata1), .mem_rdata_in(mem_rdata1),
    .busy_out(busy1)
  );

  // Memory model: data valid only in the cycle exactly MEM_LATENCY after the command.
  always @(posedge clk) begin
    pipe0 <= {pipe0[6:0], mem_req0};
    pipe1 <= mem_req1;
  end
  assign mem_rdata0 = pipe0[4] ? rd_pattern : junk;
  assign mem_rdata1 = pipe1 ? rd_pattern : junk;

  // Protocol monitor: overlapping acks, stretched acks, rdata without ack.
  int   viol = 0;
  logic prev_ic0 = 1'b0, prev_dc0 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ic_ack0 && dc_ack0) viol++;
      if (ic_ack1 && dc_ack1) viol++;
      if (ic_ack0 && prev_ic0) viol++;
      if (dc_ack0 && prev_dc0) viol++;
      if (!ic_ack0 && ic_rdata0 != '0) viol++;
      if (!dc_ack0 && dc_rdata0 != '0) viol++;
      if (!ic_ack1 && ic_rdata1 != '0) viol++;
      if (!dc_ack1 && dc_rdata1 != '0) viol++;
    end
    prev_ic0 <= ic_ack0;
    prev_dc0 <= dc_ack0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int ack_at, ack_n, ic_at, dc_at, dc_iss, iss_at, n_g;
    int order [4];
    logic raise_ic, raise_dc;

    rst = 1'b1;
    rd_pattern = {16{8'hA5}};
    ic_req0 = 0; dc_req0 = 0; dc_we0 = 0; ic_addr0 = '0; dc_addr0 = '0; dc_wdata0 = '0;
    ic_req1 = 0; dc_req1 = 0; dc_we1 = 0; ic_addr1 = '0; dc_addr1 = '0; dc_wdata1 = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 128'(busy0), 128'(0));
    check("rst_mem_req", 128'(mem_req0), 128'(0));
    check("rst_mem_addr", 128'(mem_addr0), 128'(0));
    check("rst_acks", 128'({ic_ack0, dc_ack0}), 128'(0));
    check("rst_ic_rdata", ic_rdata0, 128'(0));
    rst = 1'b0;

    // Single icache read, address aligned, ack at cycle 7
    ic_addr0 = 32'h0000_1004;
    ic_req0  = 1'b1;
    ack_at = -1; ack_n = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        check("t1_mem_req", 128'(mem_req0), 128'(1));
        check("t1_mem_we", 128'(mem_we0), 128'(0));
        check("t1_mem_addr", 128'(mem_addr0), 128'(32'h0000_1000));
        check("t1_busy", 128'(busy0), 128'(1));
      end
      if (k == 2) check("t1_req_drop", 128'(mem_req0), 128'(0));
      if (ic_ack0) begin
        ack_n++;
        ack_at = k;
        check("t1_ic_rdata", ic_rdata0, rd_pattern);
        ic_req0 = 1'b0;
      end
    end
    check("t1_ack_cycle", 128'(ack_at), 128'(7));
    check("t1_ack_count", 128'(ack_n), 128'(1));

    // Simultaneous reads after reset: ic first, then dc
    reset_pulse();
    ic_addr0 = 32'h0000_1100;
    dc_addr0 = 32'h0000_3000;
    dc_we0   = 1'b0;
    ic_req0  = 1'b1;
    dc_req0  = 1'b1;
    ic_at = -1; dc_at = -1; dc_iss = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (mem_req0 && mem_addr0 == 32'h0000_3000) dc_iss = k;
      if (ic_ack0) begin ic_at = k; ic_req0 = 1'b0; end
      if (dc_ack0) begin
        dc_at = k;
        dc_req0 = 1'b0;
        check("t2_dc_rdata", dc_rdata0, rd_pattern);
      end
    end
    check("t2_ic_ack", 128'(ic_at), 128'(7));
    check("t2_dc_issue", 128'(dc_iss), 128'(9));
    check("t2_dc_ack", 128'(dc_at), 128'(15));

    // Continuous contention: grants must alternate
    reset_pulse();
    ic_req0 = 1'b1;
    dc_req0 = 1'b1;
    n_g = 0; raise_ic = 0; raise_dc = 0;
    for (int k = 1; k <= 80 && n_g < 4; k++) begin
      tick();
      if (raise_ic) begin ic_req0 = 1'b1; raise_ic = 0; end
      if (raise_dc) begin dc_req0 = 1'b1; raise_dc = 0; end
      if (ic_ack0) begin order[n_g] = 0; n_g++; ic_req0 = 1'b0; raise_ic = 1; end
      if (dc_ack0 && n_g < 4) begin order[n_g] = 1; n_g++; dc_req0 = 1'b0; raise_dc = 1; end
    end
    ic_req0 = 1'b0;
    dc_req0 = 1'b0;
    check("t3_n_grants", 128'(n_g), 128'(4));
    for (int i = 0; i < 4; i++) check($sformatf("t3_order%0d", i), 128'(order[i]), 128'(i % 2));
    repeat (2) tick();

    // dcache writeback: command fields, ack with zero data
    dc_we0    = 1'b1;
    dc_addr0  = 32'h0000_2010;
    dc_wdata0 = 128'h1234;
    dc_req0   = 1'b1;
    iss_at = -1; ack_at = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (mem_req0) begin
        iss_at = k;
        check("t4_mem_we", 128'(mem_we0), 128'(1));
        check("t4_mem_addr", 128'(mem_addr0), 128'(32'h0000_2010));
        check("t4_mem_wdata", mem_wdata0, 128'h1234);
      end
      if (k == 2) check("t4_we_outside", 128'(mem_we0), 128'(0));
      if (k == 3) check("t4_addr_hold", 128'(mem_addr0), 128'(32'h0000_2010));
      if (dc_ack0) begin
        ack_at = k;
        check("t4_dc_rdata", dc_rdata0, 128'(0));
        dc_req0 = 1'b0;
      end
    end
    dc_we0 = 1'b0;
    check("t4_issue", 128'(iss_at), 128'(1));
    check("t4_ack", 128'(ack_at), 128'(7));

    // Reset mid-transaction abandons it; new request completes normally
    ic_addr0 = 32'h0000_4008;
    ic_req0  = 1'b1;
    ack_at = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) rst = 1'b1;
      if (k == 4) begin
        rst = 1'b0;
        ic_req0 = 1'b0;
        check("t5_rst_outs", 128'({mem_req0, mem_we0, busy0, ic_ack0, dc_ack0}), 128'(0));
        check("t5_rst_addr", 128'(mem_addr0), 128'(0));
      end
      if (k == 5) ic_req0 = 1'b1;
      if (k == 6) check("t5_reissue", 128'({mem_req0, mem_addr0}), 128'({1'b1, 32'h0000_4000}));
      if (ic_ack0) begin
        if (ack_at < 0) ack_at = k;
        ic_req0 = 1'b0;
      end
    end
    check("t5_ack", 128'(ack_at), 128'(12));

    // Latency-1 instance: dcache read
    dc_addr1 = 32'h0000_5020;
    dc_req1  = 1'b1;
    ack_at = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) check("t6_issue", 128'({mem_req1, mem_addr1}), 128'({1'b1, 32'h0000_5020}));
      if (dc_ack1) begin
        ack_at = k;
        check("t6_dc_rdata", dc_rdata1, rd_pattern);
        dc_req1 = 1'b0;
      end
    end
    check("t6_ack", 128'(ack_at), 128'(3));

    check("protocol_viol", 128'(viol), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
